// File: rtl/irq_source_unit_pkg.sv
// Shared constants for the machine interrupt source: register word offsets,
// mcause interrupt codes and the mstatus.MIE bit index used by the exception unit.
package irq_source_unit_pkg;

    // Word index within the 32-byte window (mem_addr[4:2])
    localparam logic [2:0] REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] REG_MSIP        = 3'd4;
    localparam logic [2:0] REG_EXT_PEND    = 3'd5;
    localparam logic [2:0] REG_EXT_EN      = 3'd6;
    localparam logic [2:0] REG_RSVD        = 3'd7;

    // Interrupt cause codes
    localparam logic [3:0] CAUSE_NONE = 4'd0;
    localparam logic [3:0] CAUSE_MSI  = 4'd3;
    localparam logic [3:0] CAUSE_MTI  = 4'd7;
    localparam logic [3:0] CAUSE_MEI  = 4'd11;

    // mstatus.MIE bit position
    localparam int unsigned MSTATUS_MIE_BIT = 3;

    // Isolate the lowest set bit (two's-complement trick)
    function automatic logic [31:0] lowest_set(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchronizer for one asynchronous interrupt line followed by a
// rising-edge detector; rise_o pulses for one cycle per synchronized rise.
module irq_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    output logic rise_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;

    // Shift the line through the synchronizer and the edge-history flop
    always_comb begin
        sync1_d = irq_i;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    // State update; reset drops any edge still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
        end
    end

    assign rise_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/irq_source_unit.sv
// Memory-mapped machine interrupt source: 64-bit mtime/mtimecmp timer,
// software interrupt bit and N_EXT edge-triggered external lines. Drives a
// registered level interrupt plus cause code to the exception unit.
module irq_source_unit
    import irq_source_unit_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned N_EXT     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic             mem_we,
    input  logic             mem_re,
    output logic [31:0]      mem_rdata,
    output logic             mem_rvalid,
    input  logic [N_EXT-1:0] ext_irq_in,
    input  logic             irq_ack,
    output logic             interrupt,
    output logic [3:0]       irq_cause
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]    presc_q, presc_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic             msip_q, msip_d;
    logic [N_EXT-1:0] ext_pend_q, ext_pend_d;
    logic [N_EXT-1:0] ext_en_q, ext_en_d;
    logic             interrupt_q, interrupt_d;
    logic [3:0]       cause_q, cause_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    logic             hit, wr, rd, tick;
    logic [2:0]       word;
    logic [N_EXT-1:0] ext_rise, ack_mask, w1c_mask;
    logic [31:0]      cand32, low32, pend32, en32;
    logic             timer_p, soft_p, ext_p;
    logic             unused_bits;

    assign hit  = (mem_addr[31:5] == BASE_ADDR[31:5]);
    assign word = mem_addr[4:2];
    assign wr   = mem_we & hit;
    assign rd   = mem_re & hit;
    assign tick = (presc_q == PW'(PRESCALE - 1));

    for (genvar i = 0; i < N_EXT; i++) begin : g_sync
        irq_edge_sync u_sync (
            .clk    (clk),
            .rst    (rst),
            .irq_i  (ext_irq_in[i]),
            .rise_o (ext_rise[i])
        );
    end

    // Prescaler and mtime: a bus write to either half suppresses the increment
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        mtime_d = mtime_q;
        if (wr && word == REG_MTIME_LO) begin
            mtime_d[31:0] = mem_wdata;
        end else if (wr && word == REG_MTIME_HI) begin
            mtime_d[63:32] = mem_wdata;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // Software-writable configuration registers
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        ext_en_d   = ext_en_q;
        if (wr) begin
            unique case (word)
                REG_MTIMECMP_LO: mtimecmp_d[31:0]  = mem_wdata;
                REG_MTIMECMP_HI: mtimecmp_d[63:32] = mem_wdata;
                REG_MSIP:        msip_d            = mem_wdata[0];
                REG_EXT_EN:      ext_en_d          = mem_wdata[N_EXT-1:0];
                default: ;
            endcase
        end
    end

    // External pending: W1C and ack clear, a fresh edge always wins
    always_comb begin
        cand32             = '0;
        cand32[N_EXT-1:0]  = ext_pend_q & ext_en_q;
        low32              = lowest_set(cand32);
        ack_mask           = (irq_ack && cause_q == CAUSE_MEI) ? low32[N_EXT-1:0] : '0;
        w1c_mask           = (wr && word == REG_EXT_PEND) ? mem_wdata[N_EXT-1:0] : '0;
        ext_pend_d         = (ext_pend_q & ~w1c_mask & ~ack_mask) | ext_rise;
    end

    // Pending sources and prioritized cause for the exception unit
    always_comb begin
        timer_p     = (mtime_q >= mtimecmp_q);
        soft_p      = msip_q;
        ext_p       = |(ext_pend_q & ext_en_q);
        interrupt_d = timer_p | soft_p | ext_p;
        if (ext_p) begin
            cause_d = CAUSE_MEI;
        end else if (soft_p) begin
            cause_d = CAUSE_MSI;
        end else if (timer_p) begin
            cause_d = CAUSE_MTI;
        end else begin
            cause_d = CAUSE_NONE;
        end
    end

    // Read mux samples pre-update state, so read-during-write returns the old value
    always_comb begin
        pend32            = '0;
        pend32[N_EXT-1:0] = ext_pend_q;
        en32              = '0;
        en32[N_EXT-1:0]   = ext_en_q;
        rdata_d           = rdata_q;
        rvalid_d          = rd;
        if (rd) begin
            unique case (word)
                REG_MTIME_LO:    rdata_d = mtime_q[31:0];
                REG_MTIME_HI:    rdata_d = mtime_q[63:32];
                REG_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                REG_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                REG_MSIP:        rdata_d = {31'd0, msip_q};
                REG_EXT_PEND:    rdata_d = pend32;
                REG_EXT_EN:      rdata_d = en32;
                REG_RSVD:        rdata_d = 32'd0;
                default:         rdata_d = 32'd0;
            endcase
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            mtime_q     <= 64'd0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            ext_pend_q  <= '0;
            ext_en_q    <= '0;
            interrupt_q <= 1'b0;
            cause_q     <= CAUSE_NONE;
            rdata_q     <= 32'd0;
            rvalid_q    <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            ext_pend_q  <= ext_pend_d;
            ext_en_q    <= ext_en_d;
            interrupt_q <= interrupt_d;
            cause_q     <= cause_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign interrupt  = interrupt_q;
    assign irq_cause  = cause_q;
    assign mem_rdata  = rdata_q;
    assign mem_rvalid = rvalid_q;

    // Byte-lane bits and upper bits of the one-hot helper are intentionally unused
    assign unused_bits = ^{mem_addr[1:0], low32};

endmodule

// File: doc/irq_source_unit.md
Name: irq_source_unit

Overview:
- Memory-mapped machine interrupt source for the RISC-V pipeline.
- Sits on the data-memory bus alongside RAM. Owns a 64-bit mtime/mtimecmp timer, a software-interrupt bit and N_EXT edge-triggered external lines.
- Drives the level-sensitive `interrupt` input of the exception/CSR logic, plus a cause code. Consumes an acknowledge pulse when the core actually takes the trap.

Parameters:
- BASE_ADDR, 32'hFFFF_0000: byte base of the 32-byte register window; the window is aligned to 32 bytes.
- PRESCALE, 1: clk cycles per mtime increment; must be >= 1.
- N_EXT, 4: number of external interrupt lines; 1..32.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mem_addr  in  32  byte address from the MEM stage
- mem_wdata  in  32  store data
- mem_we  in  1  word store strobe; counts only when the address hits the window
- mem_re  in  1  word load strobe; counts only when the address hits the window
- mem_rdata  out  32  registered read data
- mem_rvalid  out  1  high one cycle after an accepted read
- ext_irq_in  in  N_EXT  asynchronous external interrupt requests
- irq_ack  in  1  one-cycle pulse from the exception unit when it redirects to mtvec on an interrupt
- interrupt  out  1  registered interrupt request to the exception unit
- irq_cause  out  4  registered cause: 11 = external, 3 = software, 7 = timer, 0 = none

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - mtime = 0; mtimecmp = all ones, so no timer interrupt out of reset.
  - msip = 0, ext_pend = 0, ext_en = 0, prescaler = 0, synchronizers = 0.
  - interrupt = 0, irq_cause = 0, mem_rdata = 0, mem_rvalid = 0.
- Register map (word offsets from BASE_ADDR):
  - 0x00 mtime_lo, 0x04 mtime_hi
  - 0x08 mtimecmp_lo, 0x0C mtimecmp_hi
  - 0x10 msip (bit 0, others read 0)
  - 0x14 ext_pend (write-1-to-clear)
  - 0x18 ext_en
  - 0x1C read-only 0
  - Bits above N_EXT read 0. mem_addr[1:0] is ignored.
- Hit decode: `hit = (mem_addr[31:5] == BASE_ADDR[31:5])`. Bus accesses without a hit are ignored; mem_rvalid stays 0.
- Prescaler: counts 0..PRESCALE-1. A tick is generated in the cycle the count equals PRESCALE-1, after which the count wraps to 0. On a tick mtime increments by 1, with lo->hi carry and 64-bit wrap to 0.
- mtime write priority: a bus write to mtime_lo/hi in a cycle takes precedence over the increment. The written half gets wdata, the other half holds, and no increment occurs that cycle.
- External lines:
  - Each line passes through a 2-flop synchronizer, then rising-edge detection (sync2 & ~sync3).
  - An edge sets ext_pend[i]; ext_pend[i] is set 3 cycles after the input rises.
  - If an edge and a W1C of the same bit land in the same cycle, the set wins.
- Pending sources:
  - timer_p = (mtime >= mtimecmp), unsigned 64-bit compare.
  - soft_p = msip.
  - ext_p = |(ext_pend & ext_en).
- Outputs:
  - Next state: `interrupt <= timer_p | soft_p | ext_p`.
  - irq_cause is registered with priority external > software > timer, otherwise 0.
  - Output latency is one cycle from any pending-source change.
- irq_ack handling:
  - When irq_cause == 11, irq_ack clears the lowest-index set bit of (ext_pend & ext_en).
  - For software and timer causes, irq_ack has no effect; software clears msip or rewrites mtimecmp.
  - If irq_ack and a W1C hit the same bit, it clears once. If irq_ack and a new edge hit the same bit, the set wins.
- Reads: a read with a hit returns the register value sampled in the cycle of mem_re. The value appears on mem_rdata with mem_rvalid = 1 in the next cycle. Otherwise mem_rdata holds and mem_rvalid = 0.
- Simultaneous read and write to the same register: the read returns the old value.
- Reset mid-operation: all state returns to reset values on the next edge. In-flight synchronizer edges are lost.

Decomposition:
- Shared package:
  - Register offset constants.
  - Cause codes: CAUSE_MEI = 11, CAUSE_MSI = 3, CAUSE_MTI = 7.
  - mstatus.MIE bit index (3), shared with the exception unit.
- Sub-module `irq_edge_sync`: one instance per line, generate loop. Contains the 2-flop synchronizer plus the edge-detect flop, and outputs a one-cycle rise pulse.

Test Plan:
- Reset: assert rst 2 cycles, release → interrupt = 0, irq_cause = 0; read 0x08/0x0C → 0xFFFFFFFF both, mem_rvalid = 1 one cycle after each mem_re.
- Timer fires: PRESCALE = 1, write mtimecmp_hi = 0, mtimecmp_lo = 20 → interrupt = 1, irq_cause = 7 in the cycle after mtime reaches 20. Rewrite mtimecmp_lo = 0xFFFFFFFF, mtimecmp_hi = 0xFFFFFFFF → interrupt = 0 one cycle later.
- Carry and write priority: write mtime_lo = 0xFFFFFFFF → next tick gives hi = 1, lo = 0. Write mtime_lo = 5 on a tick cycle → reads 5, not 6.
- External edge and ack: ext_en = 0b0101, raise ext_irq_in[2] and ext_irq_in[0] in the same cycle → ext_pend = 0b0101 three cycles later, then interrupt = 1, irq_cause = 11. First irq_ack clears bit 0; second irq_ack clears bit 2, then interrupt = 0.
- Priority: msip = 1 with timer pending → irq_cause = 3. Set ext_pend[1] with ext_en[1] = 1 → irq_cause = 11. Disable ext_en → irq_cause returns to 3.
- Set-vs-clear: W1C 0x14 = 0b0010 in the same cycle an edge on line 1 is detected → ext_pend[1] remains 1.
